// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared definitions for the MIPS control paths: opcode/funct values, ALU codes,
// datapath mux selects and the multi-cycle FSM state encoding.
package mips_multicycle_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_JR  = 6'b001000;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_REG    = 2'b11;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEM_ADR = 4'd2;
  localparam logic [3:0] S_MEM_RD  = 4'd3;
  localparam logic [3:0] S_MEM_WB  = 4'd4;
  localparam logic [3:0] S_MEM_WR  = 4'd5;
  localparam logic [3:0] S_EXEC    = 4'd6;
  localparam logic [3:0] S_ALU_WB  = 4'd7;
  localparam logic [3:0] S_ADDI_EX = 4'd8;
  localparam logic [3:0] S_ADDI_WB = 4'd9;
  localparam logic [3:0] S_BRANCH  = 4'd10;
  localparam logic [3:0] S_JUMP    = 4'd11;
  localparam logic [3:0] S_JAL     = 4'd12;
  localparam logic [3:0] S_JR      = 4'd13;
  localparam logic [3:0] S_HALT    = 4'd14;

endpackage

// File: rtl/mips_multicycle_ctrl_alu_decoder.sv
// R-type funct to ALU operation decoder, shared with the single-cycle control unit.
// jr is not an ALU operation, so it reports as not legal here.
module alu_decoder
  import mips_multicycle_ctrl_pkg::*;
(
  input  logic [5:0] i_funct,
  output logic [2:0] o_alu_control,
  output logic       o_legal
);

  // NOTE: both outputs get a default before the case so no path leaves them unassigned (no latch).
  always_comb begin
    o_alu_control = ALU_ADD;
    o_legal       = 1'b1;
    case (i_funct)
      F_ADD:   o_alu_control = ALU_ADD;
      F_SUB:   o_alu_control = ALU_SUB;
      F_AND:   o_alu_control = ALU_AND;
      F_OR:    o_alu_control = ALU_OR;
      F_SLT:   o_alu_control = ALU_SLT;
      default: o_legal       = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM with ready-handshaked memory, wait-timeout bus
// error and a sticky HALT state.
module mips_multicycle_ctrl
  import mips_multicycle_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int TW      = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_en,
  output logic [1:0] pc_source,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       memto_reg,
  output logic       link,
  output logic       illegal,
  output logic       bus_error,
  output logic [3:0] state
);

  logic [3:0]    r_state;
  logic [3:0]    w_next;
  logic [3:0]    w_decode_next;
  logic          w_decode_illegal;
  logic [TW-1:0] r_wait;
  logic          r_bus_error;
  logic [2:0]    w_funct_alu;
  logic          w_funct_legal;
  logic          w_waiting;
  logic          w_timeout;

  alu_decoder u_alu_decoder (
    .i_funct       (funct),
    .o_alu_control (w_funct_alu),
    .o_legal       (w_funct_legal)
  );

  assign w_waiting = ((r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR))
                     && !mem_ready;
  assign w_timeout = w_waiting && (r_wait == TW'(TIMEOUT - 1));

  always_comb begin
    w_decode_next    = S_FETCH;
    w_decode_illegal = 1'b0;
    case (opcode)
      OP_LW, OP_SW:   w_decode_next = S_MEM_ADR;
      OP_ADDI:        w_decode_next = S_ADDI_EX;
      OP_BEQ, OP_BNE: w_decode_next = S_BRANCH;
      OP_J:           w_decode_next = S_JUMP;
      OP_JAL:         w_decode_next = S_JAL;
      OP_RTYPE: begin
        if (funct == F_JR)      w_decode_next = S_JR;
        else if (w_funct_legal) w_decode_next = S_EXEC;
        else                    w_decode_illegal = 1'b1;
      end
      default:        w_decode_illegal = 1'b1;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:   if (mem_ready) w_next = S_DECODE;
      S_DECODE:  w_next = w_decode_next;
      S_MEM_ADR: w_next = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:  if (mem_ready) w_next = S_MEM_WB;
      S_MEM_WR:  if (mem_ready) w_next = S_FETCH;
      S_EXEC:    w_next = S_ALU_WB;
      S_ADDI_EX: w_next = S_ADDI_WB;
      S_HALT:    w_next = S_HALT;
      default:   w_next = S_FETCH;
    endcase
    if (w_timeout) w_next = S_HALT;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_FETCH;
      r_wait      <= '0;
      r_bus_error <= 1'b0;
    end else begin
      r_state <= w_next;
      r_wait  <= (w_waiting && (w_next == r_state)) ? r_wait + TW'(1) : '0;
      if (w_timeout) r_bus_error <= 1'b1;
    end
  end

  always_comb begin
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    iord        = 1'b0;
    ir_write    = 1'b0;
    pc_en       = 1'b0;
    pc_source   = PC_ALU;
    alu_src_a   = 1'b0;
    alu_src_b   = SRCB_REG;
    alu_control = 3'b000;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    memto_reg   = 1'b0;
    link        = 1'b0;
    illegal     = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_read    = 1'b1;
        alu_src_b   = SRCB_FOUR;
        alu_control = ALU_ADD;
        ir_write    = mem_ready;
        pc_en       = mem_ready;
      end
      S_DECODE: begin
        alu_src_b   = SRCB_IMM_SH;
        alu_control = ALU_ADD;
        illegal     = w_decode_illegal;
      end
      S_MEM_ADR, S_ADDI_EX: begin
        alu_src_a   = 1'b1;
        alu_src_b   = SRCB_IMM;
        alu_control = ALU_ADD;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEM_WB: begin
        reg_write = 1'b1;
        memto_reg = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_EXEC: begin
        alu_src_a   = 1'b1;
        alu_control = w_funct_alu;
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_ADDI_WB: reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a   = 1'b1;
        alu_control = ALU_SUB;
        pc_source   = PC_ALUOUT;
        pc_en       = ((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero);
      end
      S_JUMP: begin
        pc_source = PC_JUMP;
        pc_en     = 1'b1;
      end
      S_JAL: begin
        reg_write = 1'b1;
        link      = 1'b1;
        pc_source = PC_JUMP;
        pc_en     = 1'b1;
      end
      S_JR: begin
        pc_source = PC_REG;
        pc_en     = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus_error = r_bus_error;
  assign state     = r_state;

endmodule
